// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back path: source tags and the
// buffered load request payload.
package wb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LD   = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for load results that lost write-port arbitration.
// A push and a pop in the same cycle are both honoured, even when full.
module wb_fifo
    import wb_pkg::*;
#(
    parameter type         T     = wb_req_t,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  T                 i_data,
    output T                 o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        w_full    = (r_count == CNT_W'(DEPTH));
        w_do_pop  = i_pop && (r_count != '0);
        w_do_push = i_push && (!w_full || w_do_pop);
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/reg_writeback.sv
// Register-file write sequencer: ALU > buffered load > bypassed load, one
// registered write per cycle, plus the outstanding-load scoreboard.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    input  logic [ADDR_W-1:0]       alu_rd,
    input  logic [WIDTH-1:0]        alu_data,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [ADDR_W-1:0]       ld_rd,
    input  logic [WIDTH-1:0]        ld_data,
    input  logic                    issue_valid,
    input  logic [ADDR_W-1:0]       issue_rd,
    output logic [(1<<ADDR_W)-1:0]  pend,
    output logic                    waw_err,
    output logic                    RegWrite,
    output logic [ADDR_W-1:0]       rd,
    output logic [WIDTH-1:0]        WD
);

    localparam int unsigned NREG  = 1 << ADDR_W;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    logic                r_we;
    wb_src_e             r_src;
    logic [ADDR_W-1:0]   r_rd;
    logic [WIDTH-1:0]    r_wd;
    logic [NREG-1:0]     r_pend;
    logic                r_waw;

    wb_req_t             w_ld_req;
    wb_req_t             w_head;
    logic [CNT_W-1:0]    w_count;
    logic                w_empty;
    logic                w_alu_eff;
    logic                w_ld_hs;
    logic                w_bypass;
    logic                w_push;
    logic                w_pop;
    wb_src_e             w_nxt_src;
    logic [ADDR_W-1:0]   w_nxt_rd;
    logic [WIDTH-1:0]    w_nxt_wd;
    logic [NREG-1:0]     w_pend_clr;
    logic [NREG-1:0]     w_pend_set;
    logic [NREG-1:0]     w_pend_nxt;
    logic                w_waw_hit;

    assign w_ld_req.rd   = ld_rd;
    assign w_ld_req.data = ld_data;

    wb_fifo #(
        .T     (wb_req_t),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_ld_req),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign ld_ready = (w_count < CNT_W'(BUF_DEPTH)) && !rst;

    always_comb begin
        w_alu_eff = alu_valid && (alu_rd != '0);
        w_ld_hs   = ld_valid && ld_ready;
        w_pop     = !w_alu_eff && !w_empty;
        w_bypass  = w_empty && !w_alu_eff && w_ld_hs;
        w_push    = w_ld_hs && !w_bypass;
    end

    // Write-port arbitration; loads to x0 consume their slot but write nothing.
    always_comb begin
        w_nxt_src = WB_NONE;
        w_nxt_rd  = r_rd;
        w_nxt_wd  = r_wd;
        if (w_alu_eff) begin
            w_nxt_src = WB_ALU;
            w_nxt_rd  = alu_rd;
            w_nxt_wd  = alu_data;
        end else if (w_pop) begin
            if (w_head.rd != '0) begin
                w_nxt_src = WB_LD;
                w_nxt_rd  = w_head.rd;
                w_nxt_wd  = w_head.data;
            end
        end else if (w_bypass) begin
            if (ld_rd != '0) begin
                w_nxt_src = WB_LD;
                w_nxt_rd  = ld_rd;
                w_nxt_wd  = ld_data;
            end
        end
    end

    // Clear follows the register file capturing a load write; set wins ties.
    always_comb begin
        w_pend_clr = '0;
        w_pend_set = '0;
        if (r_src == WB_LD) begin
            w_pend_clr = NREG'(1) << r_rd;
        end
        if (issue_valid && (issue_rd != '0)) begin
            w_pend_set = NREG'(1) << issue_rd;
        end
        w_pend_nxt = ((r_pend & ~w_pend_clr) | w_pend_set) & ~NREG'(1);
        w_waw_hit  = w_alu_eff && r_pend[alu_rd];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_src  <= WB_NONE;
            r_rd   <= '0;
            r_wd   <= '0;
            r_pend <= '0;
            r_waw  <= 1'b0;
        end else begin
            r_we   <= (w_nxt_src != WB_NONE);
            r_src  <= w_nxt_src;
            r_rd   <= w_nxt_rd;
            r_wd   <= w_nxt_wd;
            r_pend <= w_pend_nxt;
            r_waw  <= r_waw || w_waw_hit;
        end
    end

    assign RegWrite = r_we;
    assign rd       = r_rd;
    assign WD       = r_wd;
    assign pend     = r_pend;
    assign waw_err  = r_waw;

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: stimulus predicts each cycle's write
// with a queue-based model; a negedge monitor compares the DUT against it.
module tb_reg_writeback;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_rd = '0;
    logic [31:0] ld_data = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [31:0] pend;
    logic        waw_err;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] WD;

    always #5 clk = ~clk;

    reg_writeback #(.WIDTH(32), .ADDR_W(5), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .pend(pend), .waw_err(waw_err),
        .RegWrite(RegWrite), .rd(rd), .WD(WD)
    );

    typedef struct {
        int          due;
        bit          we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [31:0] pend;
        bit          waw;
    } exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ld_t;

    exp_t        exp_q[$];
    ld_t         m_buf[$];
    logic [31:0] m_pend = '0;
    bit          m_waw = 1'b0;
    bit          m_prev_ld = 1'b0;
    logic [4:0]  m_prev_rd = '0;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One stimulus cycle: drive inputs, check ready, predict the next write.
    task automatic step(input bit r, input bit av, input logic [4:0] ar, input logic [31:0] ad,
                        input bit lv, input logic [4:0] lr, input logic [31:0] ldd,
                        input bit iv, input logic [4:0] ir);
        exp_t        e;
        ld_t         h;
        bit          ready;
        bit          hs;
        bit          alu_eff;
        logic [31:0] clr;
        logic [31:0] set;
        @(posedge clk);
        #1;
        rst = r; alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_valid = lv; ld_rd = lr; ld_data = ldd;
        issue_valid = iv; issue_rd = ir;
        #1;
        ready = !r && (m_buf.size() < DEPTH);
        check("ld_ready", 32'(ld_ready), 32'(ready));
        e.due = cyc + 1; e.we = 0; e.rd = '0; e.wd = '0;
        if (r) begin
            m_buf.delete();
            m_pend = '0; m_waw = 0; m_prev_ld = 0;
        end else begin
            hs = lv && ready;
            alu_eff = av && (ar != 0);
            clr = m_prev_ld ? (32'd1 << m_prev_rd) : 32'd0;
            set = (iv && ir != 0) ? (32'd1 << ir) : 32'd0;
            if (alu_eff && m_pend[ar]) m_waw = 1;
            m_pend = ((m_pend & ~clr) | set) & ~32'd1;
            m_prev_ld = 0;
            if (alu_eff) begin
                e.we = 1; e.rd = ar; e.wd = ad;
                if (hs) m_buf.push_back('{lr, ldd});
            end else if (m_buf.size() > 0) begin
                h = m_buf.pop_front();
                if (h.rd != 0) begin
                    e.we = 1; e.rd = h.rd; e.wd = h.data;
                    m_prev_ld = 1; m_prev_rd = h.rd;
                end
                if (hs) m_buf.push_back('{lr, ldd});
            end else if (hs && lr != 0) begin
                e.we = 1; e.rd = lr; e.wd = ldd;
                m_prev_ld = 1; m_prev_rd = lr;
            end
        end
        e.pend = m_pend;
        e.waw  = m_waw;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                check("RegWrite", 32'(RegWrite), 32'(e.we));
                if (e.we) begin
                    check("rd", 32'(rd), 32'(e.rd));
                    check("WD", WD, e.wd);
                end
                check("pend", pend, e.pend);
                check("waw_err", 32'(waw_err), 32'(e.waw));
            end
        end
    end

    initial begin : stim
        int n;
        // Reset with a load offered
        step(1, 0, 0, 0, 1, 5'd3, 32'h33, 0, 0);
        step(1, 0, 0, 0, 1, 5'd3, 32'h33, 0, 0);
        @(negedge clk);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_WD", WD, 32'd0);
        // ALU path, then ALU to x0
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        step(0, 1, 5'd0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        // Bypass with scoreboard set/clear
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7);
        step(0, 0, 0, 0, 1, 5'd7, 32'h1234, 0, 0);
        idle(2);
        // Contention: buffer fills, drains after ALU burst
        step(0, 1, 5'd1, 32'h11, 1, 5'd8, 32'hA, 0, 0);
        step(0, 1, 5'd2, 32'h22, 1, 5'd9, 32'hB, 0, 0);
        step(0, 1, 5'd3, 32'h33, 1, 5'd10, 32'hC, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 5'd10, 32'hC, 0, 0);
        idle(3);
        // Same-edge clear and set of x4, then WAW
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd4);
        step(0, 0, 0, 0, 1, 5'd4, 32'h44, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd4);
        idle(1);
        step(0, 1, 5'd4, 32'h4444, 0, 0, 0, 0, 0);
        idle(2);
        // Reset with loads buffered and bits pending
        step(0, 1, 5'd1, 32'h1, 1, 5'd12, 32'hC12, 1, 5'd12);
        step(0, 1, 5'd2, 32'h2, 1, 5'd13, 32'hC13, 1, 5'd13);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 31)));
        end
        idle(4);
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
